// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables, S-boxes, shared typedefs and IP/FP helpers.
package des_pkg;
  typedef logic [63:0] block_t;
  typedef logic [31:0] half_t;
  typedef logic [47:0] rkey_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // Tables hold 1-based source bit numbers, bit 1 being the MSB.
  localparam int ip_t [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int fp_t [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int e_t [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int p_t [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // Row-major: entry index = row*16 + col.
  localparam logic [3:0] sbox_t [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
  function automatic logic [3:0] sbox(input int n, input logic [5:0] x);
    return sbox_t[n][{x[5], x[0], x[4:1]}];
  endfunction
  function automatic block_t ip_f(input block_t d);
    block_t o;
    for (int i = 0; i < 64; i++) o[63-i] = d[64-ip_t[i]];
    return o;
  endfunction
  function automatic block_t fp_f(input block_t d);
    block_t o;
    for (int i = 0; i < 64; i++) o[63-i] = d[64-fp_t[i]];
    return o;
  endfunction
endpackage

// File: rtl/des_encryption_if.sv
// des_encryption_if: block, round-key and handshake bundle between packet buffer, key scheduler and output path.
interface des_encryption_if;
  import des_pkg::*;
  logic EOP_flag;
  logic mode;
  block_t in;
  rkey_t in_key00, in_key01, in_key02, in_key03, in_key04, in_key05, in_key06, in_key07;
  rkey_t in_key08, in_key09, in_key10, in_key11, in_key12, in_key13, in_key14, in_key15;
  logic encrypt_done;
  block_t out;
  logic out_valid;
  modport master (
    output EOP_flag, mode, in, encrypt_done,
    output in_key00, in_key01, in_key02, in_key03, in_key04, in_key05, in_key06, in_key07,
    output in_key08, in_key09, in_key10, in_key11, in_key12, in_key13, in_key14, in_key15,
    input out, out_valid
  );
  modport slave (
    input EOP_flag, mode, in, encrypt_done,
    input in_key00, in_key01, in_key02, in_key03, in_key04, in_key05, in_key06, in_key07,
    input in_key08, in_key09, in_key10, in_key11, in_key12, in_key13, in_key14, in_key15,
    output out, out_valid
  );
endinterface

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round, (L, R, K) -> (R, L ^ P(S(E(R) ^ K))).
module des_round
  import des_pkg::*;
(
  input  half_t l,
  input  half_t r,
  input  rkey_t k,
  output half_t l_n,
  output half_t r_n
);
  rkey_t e;
  rkey_t x;
  half_t s;
  half_t f;
  always_comb begin
    e = '0;
    s = '0;
    f = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
    x = e ^ k;
    for (int j = 0; j < 8; j++) s[31-4*j -: 4] = sbox(j, x[47-6*j -: 6]);
    for (int i = 0; i < 32; i++) f[31-i] = s[32-p_t[i]];
  end
  assign l_n = r;
  assign r_n = l ^ f;
endmodule

// File: rtl/des_encryption.sv
// des_encryption: iterative DES core, two rounds per clock, 8-clock latency.
// Define DES_KEY_LATCH_EN to register all round keys on the EOP edge.
module des_encryption
  import des_pkg::*;
(
  input logic clk,
  input logic reset,
  des_encryption_if.slave bus
);
  state_t state, state_n;
  logic [2:0] cnt;
  half_t l, r, l1, r1, l2, r2;
  logic md;
  rkey_t ka, kb;
  rkey_t keys [16];
  rkey_t rk [16];
  logic start;
  assign keys = '{bus.in_key00, bus.in_key01, bus.in_key02, bus.in_key03,
                  bus.in_key04, bus.in_key05, bus.in_key06, bus.in_key07,
                  bus.in_key08, bus.in_key09, bus.in_key10, bus.in_key11,
                  bus.in_key12, bus.in_key13, bus.in_key14, bus.in_key15};
  assign start = bus.EOP_flag && (state == IDLE || state == DONE);
`ifdef DES_KEY_LATCH_EN
  rkey_t key_q [16];
  always_ff @(posedge clk)
    if (start) key_q <= keys;
  assign rk = key_q;
`else
  assign rk = keys;
`endif
  // Decrypt walks the schedule backwards: index 15-n is the bitwise inverse of n.
  assign ka = md ? rk[{cnt, 1'b0}] : rk[~{cnt, 1'b0}];
  assign kb = md ? rk[{cnt, 1'b1}] : rk[~{cnt, 1'b1}];
  des_round u_r0 (.l(l),  .r(r),  .k(ka), .l_n(l1), .r_n(r1));
  des_round u_r1 (.l(l1), .r(r1), .k(kb), .l_n(l2), .r_n(r2));
  always_comb begin
    state_n = state;
    if (start) state_n = RUN;
    else if (state == RUN && cnt == 3'd7) state_n = DONE;
    else if (state == DONE && bus.encrypt_done) state_n = IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      l <= '0;
      r <= '0;
      cnt <= '0;
      md <= 1'b0;
      bus.out <= '0;
      bus.out_valid <= 1'b0;
    end else if (start) begin
      {l, r} <= ip_f(bus.in);
      md <= bus.mode;
      cnt <= '0;
      bus.out_valid <= 1'b0;
    end else if (state == RUN) begin
      l <= l2;
      r <= r2;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        bus.out <= fp_f({r2, l2});
        bus.out_valid <= 1'b1;
      end
    end else if (state == DONE && bus.encrypt_done) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_des_encryption.sv
// tb_des_encryption: scoreboard bench for des_encryption with known-answer vectors and control corner cases.
module tb_des_encryption;
  import des_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  block_t exp_q [$];
  block_t last;
  des_encryption_if bus ();
  des_encryption dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic start_block(input block_t data, input logic md, input block_t exp);
    @(posedge clk);
    #1;
    bus.EOP_flag = 1'b1;
    bus.in = data;
    bus.mode = md;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.EOP_flag = 1'b0;
    bus.in = {$urandom, $urandom};
    bus.mode = $urandom_range(0, 1);
  endtask
  task automatic wait_result(input string tag, input int elapsed);
    int n = elapsed;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd8);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      last = exp_q.pop_front();
      check(tag, bus.out, last);
    end
  endtask
  task automatic ack(input string tag);
    bus.encrypt_done = 1'b1;
    @(posedge clk);
    #1;
    bus.encrypt_done = 1'b0;
    check({tag, "_ack_v"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ack_hold"}, bus.out, last);
  endtask
  initial begin
    bus.EOP_flag = 1'b0;
    bus.mode = 1'b0;
    bus.in = '0;
    bus.encrypt_done = 1'b0;
    bus.in_key00 = 48'h38acef46564a; bus.in_key01 = 48'h89bed4489d12;
    bus.in_key02 = 48'h547eee4d443c; bus.in_key03 = 48'hf2f5604958c8;
    bus.in_key04 = 48'hc8cf6780d03d; bus.in_key05 = 48'he1f31f831ea4;
    bus.in_key06 = 48'h2597e3980bb1; bus.in_key07 = 48'hf358f3134a15;
    bus.in_key08 = 48'h0cda7ba00ac6; bus.in_key09 = 48'ha7795e94a297;
    bus.in_key10 = 48'h2e6fc13706c1; bus.in_key11 = 48'h5b7d391aa143;
    bus.in_key12 = 48'hcda5d926e504; bus.in_key13 = 48'h57ce8f6825c2;
    bus.in_key14 = 48'h7bb982ecc00b; bus.in_key15 = 48'hd33a2d238d68;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out", bus.out, 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    bus.encrypt_done = 1'b1;
    @(posedge clk);
    #1;
    bus.encrypt_done = 1'b0;
    check("idle_done_valid", 64'(bus.out_valid), 64'd0);
    start_block(64'h1122334455667788, 1'b1, 64'hb5219ee81aa7499d);
    wait_result("enc1", 0);
    ack("enc1");
    start_block(64'hb5219ee81aa7499d, 1'b0, 64'h1122334455667788);
    wait_result("dec1", 0);
    ack("dec1");
    start_block(64'h99aabbccddeeff00, 1'b1, 64'h2196687e13973856);
    wait_result("enc2", 0);
    ack("enc2");
    start_block(64'h2196687e13973856, 1'b0, 64'h99aabbccddeeff00);
    wait_result("dec2", 0);
    ack("dec2");
    start_block(64'h1122334455667788, 1'b1, 64'hb5219ee81aa7499d);
    repeat (2) @(posedge clk);
    #1;
    bus.EOP_flag = 1'b1;
    bus.in = 64'h0123456789abcdef;
    bus.mode = 1'b0;
    bus.encrypt_done = 1'b1;
    @(posedge clk);
    #1;
    bus.EOP_flag = 1'b0;
    bus.encrypt_done = 1'b0;
    wait_result("mid_eop", 3);
    bus.EOP_flag = 1'b1;
    bus.encrypt_done = 1'b1;
    bus.in = 64'hb5219ee81aa7499d;
    bus.mode = 1'b0;
    exp_q.push_back(64'h1122334455667788);
    @(posedge clk);
    #1;
    bus.EOP_flag = 1'b0;
    bus.encrypt_done = 1'b0;
    check("eop_done_valid", 64'(bus.out_valid), 64'd0);
    check("eop_done_hold", bus.out, 64'hb5219ee81aa7499d);
    wait_result("eop_done", 0);
    ack("eop_done");
    start_block(64'h99aabbccddeeff00, 1'b1, 64'h2196687e13973856);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    check("abort_out", bus.out, 64'd0);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    begin
      logic seen = 1'b0;
      repeat (12) begin
        @(posedge clk);
        #1;
        seen |= bus.out_valid;
      end
      check("abort_idle", 64'(seen), 64'd0);
    end
    start_block(64'h99aabbccddeeff00, 1'b1, 64'h2196687e13973856);
    wait_result("post_abort", 0);
    ack("post_abort");
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
